// File: rtl/timer_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// timer_arbiter_pkg
// Shared definitions for the timer arbiter slice: FSM state encoding and the
// default requester count / count width used by the arbiter and its counter.
// No ports (package).
// -----------------------------------------------------------------------------
package timer_arbiter_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/timer_arbiter_tick_counter.sv
// -----------------------------------------------------------------------------
// tick_counter
// WIDTH-bit up-counter with a loadable terminal target. The equality flag is
// registered but computed from the next-state values, so in every cycle
// eq_o == (count_o == latched target) with no combinational compare on the
// output side. The counter never advances past the target.
//
// Ports:
//   clk       in   clock, rising edge
//   reset_i   in   synchronous active-high reset (count=0, target=0)
//   clr_i     in   synchronous clear of the count
//   load_i    in   latch target_i as the new terminal value
//   en_i      in   advance the count by one (ignored at target)
//   target_i  in   terminal value to latch
//   count_o   out  current count
//   eq_o      out  count has reached the latched target
// -----------------------------------------------------------------------------
module tick_counter
  import timer_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] target_i,
  output logic [WIDTH-1:0] count_o,
  output logic             eq_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             eq_q, eq_d;

  // Next count / target and the look-ahead equality flag.
  always_comb begin
    if (clr_i) begin
      count_d = {WIDTH{1'b0}};
    end else if (en_i && !eq_q) begin
      count_d = count_q + ONE;
    end else begin
      count_d = count_q;
    end

    if (load_i) begin
      target_d = target_i;
    end else begin
      target_d = target_q;
    end

    eq_d = (count_d == target_d);
  end

  // Counter, target and flag registers.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      count_q  <= {WIDTH{1'b0}};
      target_q <= {WIDTH{1'b0}};
      eq_q     <= 1'b1;
    end else begin
      count_q  <= count_d;
      target_q <= target_d;
      eq_q     <= eq_d;
    end
  end

  assign count_o = count_q;
  assign eq_o    = eq_q;

endmodule

// File: rtl/timer_arbiter.sv
// -----------------------------------------------------------------------------
// timer_arbiter
// Shares one terminal-count timer among NREQ requesters. Requests are served
// round-robin; the granted requester's length is latched, counted from 0 up to
// that value, and then a single-cycle done pulse is issued for it.
//
// Optional feature macro: TIMER_ARBITER_ABORT_EN adds the `abort` input, which
// cancels a running interval (no done pulse, count cleared).
//
// Ports:
//   clk       in   clock, rising edge
//   reset_in  in   synchronous active-high reset, dominant
//   req       in   per-requester request level
//   len       in   per-requester terminal count, slice i = [i*WIDTH +: WIDTH]
//   grant     out  one-hot, high while the owner's interval runs
//   done      out  one-hot single-cycle pulse at the end of an interval
//   busy      out  high whenever the arbiter is not idle
//   count     out  current count value
//   abort     in   (TIMER_ARBITER_ABORT_EN only) cancel the running interval
// -----------------------------------------------------------------------------
module timer_arbiter
  import timer_arbiter_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_in,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] len,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [WIDTH-1:0]      count
`ifdef TIMER_ARBITER_ABORT_EN
  ,
  input  logic                  abort
`endif
);

  localparam int                IDXW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0]   ONEHOT0  = {{(NREQ-1){1'b0}}, 1'b1};
  localparam logic [IDXW-1:0]   LAST_IDX = IDXW'(NREQ - 1);
  localparam logic [IDXW-1:0]   IDX_ONE  = {{(IDXW-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [IDXW-1:0]  ptr_q, ptr_d;
  logic [IDXW-1:0]  owner_q, owner_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic             busy_q, busy_d;

  logic [IDXW-1:0]  sel_s;
  logic             found_s;
  int               rr_idx_s;
  logic [IDXW-1:0]  rr_pos_s;
  logic             hit_s;
  logic [WIDTH-1:0] cnt_target_s;
  logic             cnt_clr_s, cnt_load_s, cnt_en_s, cnt_eq_s;
  logic             abort_s;

`ifdef TIMER_ARBITER_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // Round-robin search: first set req bit at or after the pointer, wrapping.
  always_comb begin
    found_s  = 1'b0;
    sel_s    = {IDXW{1'b0}};
    rr_idx_s = 0;
    rr_pos_s = {IDXW{1'b0}};
    hit_s    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      rr_idx_s = int'(ptr_q) + k;
      rr_idx_s = (rr_idx_s >= NREQ) ? (rr_idx_s - NREQ) : rr_idx_s;
      rr_pos_s = IDXW'(rr_idx_s);
      hit_s    = req[rr_pos_s] & ~found_s;
      sel_s    = hit_s ? rr_pos_s : sel_s;
      found_s  = found_s | hit_s;
    end
  end

  // Length slice of the selected requester (constant-index mux).
  always_comb begin
    cnt_target_s = {WIDTH{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      cnt_target_s = (sel_s == IDXW'(i)) ? len[i*WIDTH +: WIDTH] : cnt_target_s;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        state_d = found_s ? ST_COUNT : ST_IDLE;
      end
      ST_COUNT: begin
        if (abort_s) begin
          state_d = ST_IDLE;
        end else if (cnt_eq_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_COUNT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: next values of the registered outputs, pointer and counter
  // controls. Outputs are decided on the transition so they appear right
  // after the edge that causes them.
  always_comb begin
    grant_d    = {NREQ{1'b0}};
    done_d     = {NREQ{1'b0}};
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    cnt_clr_s  = 1'b0;
    cnt_load_s = 1'b0;
    cnt_en_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          grant_d    = ONEHOT0 << sel_s;
          owner_d    = sel_s;
          ptr_d      = (sel_s == LAST_IDX) ? {IDXW{1'b0}} : (sel_s + IDX_ONE);
          cnt_clr_s  = 1'b1;
          cnt_load_s = 1'b1;
        end else begin
          grant_d = {NREQ{1'b0}};
        end
      end
      ST_COUNT: begin
        if (abort_s) begin
          // Cancelled interval: count returns to zero, no done pulse.
          cnt_clr_s = 1'b1;
        end else if (cnt_eq_s) begin
          done_d = ONEHOT0 << owner_q;
        end else begin
          grant_d  = grant_q;
          cnt_en_s = 1'b1;
        end
      end
      ST_DONE: begin
        grant_d = {NREQ{1'b0}};
      end
      default: begin
        grant_d = {NREQ{1'b0}};
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, pointer and registered outputs.
  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_q <= ST_IDLE;
      ptr_q   <= {IDXW{1'b0}};
      owner_q <= {IDXW{1'b0}};
      grant_q <= {NREQ{1'b0}};
      done_q  <= {NREQ{1'b0}};
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  tick_counter #(
    .WIDTH (WIDTH)
  ) u_tick_counter (
    .clk      (clk),
    .reset_i  (reset_in),
    .clr_i    (cnt_clr_s),
    .load_i   (cnt_load_s),
    .en_i     (cnt_en_s),
    .target_i (cnt_target_s),
    .count_o  (count),
    .eq_o     (cnt_eq_s)
  );

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_timer_arbiter
// Self-checking bench for timer_arbiter (NREQ=4, WIDTH=8). A timeline model
// (elapsed cycles since the grant, compared to the latched length) predicts
// every output each cycle; a vector table and directed sequences add fixed
// expectations for the documented corner cases. Define TIMER_ARBITER_ABORT_EN
// to also exercise the abort input.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_timer_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  reset_in;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] len;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic [WIDTH-1:0]      count;
`ifdef TIMER_ARBITER_ABORT_EN
  logic                  abort;
`endif

  timer_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH)
  ) dut (
    .clk      (clk),
    .reset_in (reset_in),
    .req      (req),
    .len      (len),
    .grant    (grant),
    .done     (done),
    .busy     (busy),
    .count    (count)
`ifdef TIMER_ARBITER_ABORT_EN
    ,
    .abort    (abort)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: an interval is "active" from its grant edge; m_t counts
  // edges since that grant. t<=tgt -> granted, t==tgt+1 -> done, t==tgt+2 -> idle.
  bit   m_active = 1'b0;
  int   m_owner, m_tgt, m_t;
  int   m_ptr = 0;
  int   m_last_count = 0;
  logic [3:0] exp_grant, exp_done;
  logic       exp_busy;
  logic [7:0] exp_count;

  function automatic void model_step(input logic rst, input logic [3:0] r,
                                     input logic [31:0] l, input logic ab);
    if (rst) begin
      m_active     = 1'b0;
      m_ptr        = 0;
      m_last_count = 0;
    end else if (m_active) begin
      if (ab && m_t <= m_tgt) begin
        m_active     = 1'b0;
        m_last_count = 0;
      end else begin
        m_t++;
        if (m_t == m_tgt + 2) m_active = 1'b0;
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (!m_active && r[i]) begin
          m_active = 1'b1;
          m_owner  = i;
          m_tgt    = int'(l[i*WIDTH +: WIDTH]);
          m_t      = 0;
        end
      end
      if (m_active) m_ptr = (m_owner + 1) % NREQ;
    end
    exp_grant = 4'b0000;
    exp_done  = 4'b0000;
    exp_busy  = m_active;
    exp_count = 8'(m_last_count);
    if (m_active) begin
      if (m_t <= m_tgt) begin
        exp_grant = 4'(1 << m_owner);
        exp_count = 8'(m_t);
      end else begin
        exp_done  = 4'(1 << m_owner);
        exp_count = 8'(m_tgt);
      end
      m_last_count = int'(exp_count);
    end
  endfunction

  task automatic check_out(input string name, input logic [3:0] g, input logic [3:0] d,
                           input logic b, input logic [7:0] c);
    n_checks++;
    if (grant === g && done === d && busy === b && count === c) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got grant=%b done=%b busy=%b count=%0d, expected grant=%b done=%b busy=%b count=%0d",
               name, grant, done, busy, count, g, d, b, c);
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, want);
  endtask

  task automatic timeout(input string name);
    n_checks++;
    $display("FAIL %s: timed out waiting for done", name);
  endtask

  // One clock: drive inputs, let the edge happen, compare DUT to the model.
  task automatic cycle(input logic rst, input logic [3:0] r, input logic [31:0] l,
                       input logic ab);
    reset_in = rst;
    req      = r;
    len      = l;
`ifdef TIMER_ARBITER_ABORT_EN
    abort    = ab;
`endif
    @(posedge clk);
    model_step(rst, r, l, ab);
    #1;
    check_out("model", exp_grant, exp_done, exp_busy, exp_count);
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  r;
    logic [31:0] l;
    logic [3:0]  g;
    logic [3:0]  d;
    logic        b;
    logic [7:0]  c;
  } vec_t;

  vec_t tbl [21];

  initial begin
    logic [31:0] l;
    bit          seen;
    int          gcnt, maxc;

    // Single request of length 3, then all four requesters with length 0.
    tbl[0]  = '{1'b1, 4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 1'b0, 8'd0};
    tbl[1]  = '{1'b0, 4'b0001, 32'h0000_0003, 4'b0001, 4'b0000, 1'b1, 8'd0};
    tbl[2]  = '{1'b0, 4'b0000, 32'h0000_0003, 4'b0001, 4'b0000, 1'b1, 8'd1};
    tbl[3]  = '{1'b0, 4'b0000, 32'h0000_0003, 4'b0001, 4'b0000, 1'b1, 8'd2};
    tbl[4]  = '{1'b0, 4'b0000, 32'h0000_0003, 4'b0001, 4'b0000, 1'b1, 8'd3};
    tbl[5]  = '{1'b0, 4'b0000, 32'h0000_0003, 4'b0000, 4'b0001, 1'b1, 8'd3};
    tbl[6]  = '{1'b0, 4'b0000, 32'h0000_0003, 4'b0000, 4'b0000, 1'b0, 8'd3};
    tbl[7]  = '{1'b1, 4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 1'b0, 8'd0};
    tbl[8]  = '{1'b0, 4'b1111, 32'h0000_0000, 4'b0001, 4'b0000, 1'b1, 8'd0};
    tbl[9]  = '{1'b0, 4'b1111, 32'h0000_0000, 4'b0000, 4'b0001, 1'b1, 8'd0};
    tbl[10] = '{1'b0, 4'b1111, 32'h0000_0000, 4'b0000, 4'b0000, 1'b0, 8'd0};
    tbl[11] = '{1'b0, 4'b1111, 32'h0000_0000, 4'b0010, 4'b0000, 1'b1, 8'd0};
    tbl[12] = '{1'b0, 4'b1111, 32'h0000_0000, 4'b0000, 4'b0010, 1'b1, 8'd0};
    tbl[13] = '{1'b0, 4'b1111, 32'h0000_0000, 4'b0000, 4'b0000, 1'b0, 8'd0};
    tbl[14] = '{1'b0, 4'b1111, 32'h0000_0000, 4'b0100, 4'b0000, 1'b1, 8'd0};
    tbl[15] = '{1'b0, 4'b1111, 32'h0000_0000, 4'b0000, 4'b0100, 1'b1, 8'd0};
    tbl[16] = '{1'b0, 4'b1111, 32'h0000_0000, 4'b0000, 4'b0000, 1'b0, 8'd0};
    tbl[17] = '{1'b0, 4'b1111, 32'h0000_0000, 4'b1000, 4'b0000, 1'b1, 8'd0};
    tbl[18] = '{1'b0, 4'b1111, 32'h0000_0000, 4'b0000, 4'b1000, 1'b1, 8'd0};
    tbl[19] = '{1'b0, 4'b1111, 32'h0000_0000, 4'b0000, 4'b0000, 1'b0, 8'd0};
    tbl[20] = '{1'b0, 4'b1111, 32'h0000_0000, 4'b0001, 4'b0000, 1'b1, 8'd0};

    reset_in = 1'b1;
    req      = 4'b0000;
    len      = 32'h0;
`ifdef TIMER_ARBITER_ABORT_EN
    abort    = 1'b0;
`endif

    for (int v = 0; v < 21; v++) begin
      cycle(tbl[v].rst, tbl[v].r, tbl[v].l, 1'b0);
      check_out($sformatf("vec%0d", v), tbl[v].g, tbl[v].d, tbl[v].b, tbl[v].c);
    end

    // Two requesters; the length of requester 2 changes mid-count.
    cycle(1'b1, 4'b0000, 32'h0, 1'b0);
    l = 32'h0005_0002;
    cycle(1'b0, 4'b0101, l, 1'b0);
    check_val("rr_first_grant", int'(grant), 1);
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      if (grant[2] && count == 8'd1) l = 32'h0009_0002;
      cycle(1'b0, 4'b0101, l, 1'b0);
      if (done[2]) begin
        seen = 1'b1;
        check_val("len2_latched_count", int'(count), 5);
      end
    end
    if (!seen) timeout("len2_latched");

    // Reset in the middle of an interval.
    cycle(1'b1, 4'b0000, 32'h0, 1'b0);
    cycle(1'b0, 4'b0010, 32'h0000_0A00, 1'b0);
    cycle(1'b0, 4'b0010, 32'h0000_0A00, 1'b0);
    cycle(1'b0, 4'b0010, 32'h0000_0A00, 1'b0);
    check_val("count_before_reset", int'(count), 2);
    cycle(1'b1, 4'b0010, 32'h0000_0A00, 1'b0);
    check_out("after_mid_reset", 4'b0000, 4'b0000, 1'b0, 8'd0);
    cycle(1'b0, 4'b1111, 32'h0, 1'b0);
    check_val("ptr_reset_grant", int'(grant), 1);

    // Maximum length: no wrap, 256 grant cycles.
    cycle(1'b1, 4'b0000, 32'h0, 1'b0);
    gcnt = 0;
    maxc = 0;
    seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      cycle(1'b0, 4'b0010, 32'h0000_FF00, 1'b0);
      if (grant[1]) gcnt++;
      if (int'(count) > maxc) maxc = int'(count);
      if (done[1]) begin
        seen = 1'b1;
        check_val("max_grant_cycles", gcnt, 256);
        check_val("max_count_at_done", int'(count), 255);
        check_val("max_count_peak", maxc, 255);
      end
    end
    if (!seen) timeout("max_len");
    cycle(1'b0, 4'b0000, 32'h0, 1'b0);

`ifdef TIMER_ARBITER_ABORT_EN
    // Abort requester 3 at count 1; pointer has already moved to 0.
    cycle(1'b1, 4'b0000, 32'h0, 1'b0);
    cycle(1'b0, 4'b1000, 32'h0400_0000, 1'b0);
    check_val("abort_grant3", int'(grant), 8);
    cycle(1'b0, 4'b1000, 32'h0400_0000, 1'b0);
    cycle(1'b0, 4'b1000, 32'h0400_0000, 1'b1);
    check_out("after_abort", 4'b0000, 4'b0000, 1'b0, 8'd0);
    cycle(1'b0, 4'b1001, 32'h0400_0000, 1'b0);
    check_val("grant_after_abort", int'(grant), 1);
`endif

    // Randomized traffic against the model.
    cycle(1'b1, 4'b0000, 32'h0, 1'b0);
    for (int n = 0; n < 600; n++) begin
      logic [31:0] rl;
      logic        rr;
      logic        ra;
      for (int i = 0; i < NREQ; i++) begin
        rl[i*WIDTH +: WIDTH] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 40))
                                                           : 8'($urandom_range(0, 5));
      end
      rr = ($urandom_range(0, 79) == 0);
`ifdef TIMER_ARBITER_ABORT_EN
      ra = ($urandom_range(0, 19) == 0);
`else
      ra = 1'b0;
`endif
      cycle(rr, 4'($urandom), rl, ra);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
